// File: rtl/serial_slice_adder.sv
// serial_slice_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per
// clock. A DIGIT-bit ripple chain feeds a registered inter-slice carry, with
// valid/ready handshakes on both the operand side and the result side.
module serial_slice_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_slice_c;
    logic [DIGIT-1:0] b_slice_c;
    logic [DIGIT-1:0] sum_slice_c;
    logic [WIDTH-1:0] sum_next_c;
    logic             ripple_c;
    logic             msb_cin_c;
    logic             last_c;

    // Select the active slice, ripple it through DIGIT full-adder cells and
    // merge the slice sum into the running result.
    always_comb begin
        a_slice_c   = '0;
        b_slice_c   = '0;
        sum_slice_c = '0;
        sum_next_c  = sum_reg;
        ripple_c    = carry_reg;
        msb_cin_c   = 1'b0;
        last_c      = (cnt == CW'(STEPS - 1));

        for (int j = 0; j < STEPS; j++) begin
            if (cnt == CW'(j)) begin
                a_slice_c = a_reg[j*DIGIT +: DIGIT];
                b_slice_c = b_reg[j*DIGIT +: DIGIT];
            end
        end

        for (int i = 0; i < DIGIT; i++) begin
            // Carry into the slice MSB; on the last slice this is the carry into bit WIDTH-1.
            msb_cin_c      = ripple_c;
            sum_slice_c[i] = a_slice_c[i] ^ b_slice_c[i] ^ ripple_c;
            ripple_c       = (a_slice_c[i] & b_slice_c[i]) |
                             (ripple_c & (a_slice_c[i] ^ b_slice_c[i]));
        end

        for (int j = 0; j < STEPS; j++) begin
            if (cnt == CW'(j)) begin
                sum_next_c[j*DIGIT +: DIGIT] = sum_slice_c;
            end
        end
    end

    // Control FSM, operand/sum registers and registered handshake/result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            o_sum      <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        // Subtraction is A + ~B + 1, so the caller's carry-in is dropped.
                        a_reg     <= i_a;
                        b_reg     <= i_sub ? ~i_b : i_b;
                        carry_reg <= i_sub | i_carry;
                        sum_reg   <= '0;
                        cnt       <= '0;
                        o_ready   <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next_c;
                    carry_reg <= ripple_c;
                    cnt       <= cnt + CW'(1);
                    if (last_c) begin
                        o_sum      <= sum_next_c;
                        o_carry    <= ripple_c;
                        o_overflow <= msb_cin_c ^ ripple_c;
                        o_valid    <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slice_adder.sv
// Testbench for serial_slice_adder: directed cases plus randomized streams on
// three configurations (DIGIT = 4, 1, 16) checked against an arithmetic model.
module tb_serial_slice_adder;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         valid [3];
    logic         ready [3];
    logic         rdy_w [3];
    logic         vld_w [3];
    logic [W-1:0] sum_w [3];
    logic         car_w [3];
    logic         ovf_w [3];

    int n_cmp;
    int n_bad;

    serial_slice_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(rdy_w[0]),
        .i_a(a), .i_b(b), .i_carry(cin), .i_sub(sub),
        .o_valid(vld_w[0]), .i_ready(ready[0]), .o_sum(sum_w[0]),
        .o_carry(car_w[0]), .o_overflow(ovf_w[0])
    );

    serial_slice_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(rdy_w[1]),
        .i_a(a), .i_b(b), .i_carry(cin), .i_sub(sub),
        .o_valid(vld_w[1]), .i_ready(ready[1]), .o_sum(sum_w[1]),
        .o_carry(car_w[1]), .o_overflow(ovf_w[1])
    );

    serial_slice_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .o_ready(rdy_w[2]),
        .i_a(a), .i_b(b), .i_carry(cin), .i_sub(sub),
        .o_valid(vld_w[2]), .i_ready(ready[2]), .o_sum(sum_w[2]),
        .o_carry(car_w[2]), .o_overflow(ovf_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        int          sa;
        int          sb;
        int          r;
        logic [16:0] u;
        logic        co;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            r  = sa - sb;
            u  = {1'b0, ma} - {1'b0, mb};
            co = (ma >= mb);
        end else begin
            r  = sa + sb + int'(mc);
            u  = {1'b0, ma} + {1'b0, mb} + 17'(mc);
            co = u[16];
        end
        return {(r > 32767 || r < -32768), co, u[15:0]};
    endfunction

    // Present one operation to instance k and count cycles until o_valid (-1 on timeout).
    task automatic run_op(input int k, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic ts, output int lat);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts;
        valid[k] = 1'b1;
        ready[k] = 1'b0;
        @(posedge clk);
        #1 valid[k] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (vld_w[k]) begin
                lat = i;
                break;
            end
        end
    endtask

    // Let instance k hand off its result and return to IDLE.
    task automatic release_op(input int k);
        @(negedge clk);
        ready[k] = 1'b1;
        @(posedge clk);
        #1 ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rdy_w[k] !== 1'b1 || vld_w[k] !== 1'b0 || sum_w[k] !== 16'h0000 ||
                car_w[k] !== 1'b0 || ovf_w[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got rdy=%b vld=%b sum=%h c=%b ov=%b want rdy=1 vld=0 sum=0000 c=0 ov=0",
                         k, rdy_w[k], vld_w[k], sum_w[k], car_w[k], ovf_w[k]);
            end
        end
    endtask

    task automatic test_add();
        int lat;
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL add_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if (sum_w[0] !== 16'h0100 || car_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL add_result: got sum=%h c=%b ov=%b want sum=0100 c=0 ov=0",
                     sum_w[0], car_w[0], ovf_w[0]);
        end
        release_op(0);
    endtask

    task automatic test_wrap();
        logic [15:0] ta [3];
        logic [15:0] tb_ [3];
        logic        tc [3];
        logic [17:0] exp [3];
        int          lat;
        ta  = '{16'hFFFF, 16'h7FFF, 16'h1234};
        tb_ = '{16'h0001, 16'h0001, 16'h0000};
        tc  = '{1'b0, 1'b0, 1'b1};
        exp = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000}, {1'b0, 1'b0, 16'h1235}};
        for (int i = 0; i < 3; i++) begin
            run_op(0, ta[i], tb_[i], tc[i], 1'b0, lat);
            n_cmp++;
            if ({ovf_w[0], car_w[0], sum_w[0]} !== exp[i] || lat !== 4) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got ov/c/sum=%h lat=%0d want %h lat=4",
                         i, {ovf_w[0], car_w[0], sum_w[0]}, lat, exp[i]);
            end
            release_op(0);
        end
    endtask

    task automatic test_sub();
        logic [15:0] ta [2];
        logic [15:0] tb_ [2];
        logic [17:0] exp [2];
        int          lat;
        ta  = '{16'h0005, 16'h8000};
        tb_ = '{16'h0007, 16'h0001};
        exp = '{{1'b0, 1'b0, 16'hFFFE}, {1'b1, 1'b1, 16'h7FFF}};
        for (int i = 0; i < 2; i++) begin
            run_op(0, ta[i], tb_[i], 1'b1, 1'b1, lat);
            n_cmp++;
            if ({ovf_w[0], car_w[0], sum_w[0]} !== exp[i]) begin
                n_bad++;
                $display("FAIL sub[%0d]: got ov/c/sum=%h want %h",
                         i, {ovf_w[0], car_w[0], sum_w[0]}, exp[i]);
            end
            release_op(0);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            valid[0] = ~valid[0];
            @(posedge clk);
            #1;
            n_cmp++;
            if (vld_w[0] !== 1'b1 || rdy_w[0] !== 1'b0 || sum_w[0] !== 16'h5555 ||
                car_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b sum=%h c=%b ov=%b want vld=1 rdy=0 sum=5555 c=0 ov=0",
                         i, vld_w[0], rdy_w[0], sum_w[0], car_w[0], ovf_w[0]);
            end
        end
        @(negedge clk);
        valid[0] = 1'b1;
        ready[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        ready[0] = 1'b0;
        n_cmp++;
        if (vld_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL release: got vld=%b rdy=%b want vld=0 rdy=1", vld_w[0], rdy_w[0]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (rdy_w[0] !== 1'b1 || vld_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL no_second_accept: got rdy=%b vld=%b want rdy=1 vld=0", rdy_w[0], vld_w[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if (vld_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || sum_w[0] !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_mid: got vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=0000",
                     vld_w[0], rdy_w[0], sum_w[0]);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        n_cmp++;
        if (sum_w[0] !== 16'h0002 || car_w[0] !== 1'b0 || lat !== 4) begin
            n_bad++;
            $display("FAIL after_reset: got sum=%h c=%b lat=%0d want sum=0002 c=0 lat=4",
                     sum_w[0], car_w[0], lat);
        end
        release_op(0);
    endtask

    task automatic test_config(input int k, input int exp_lat);
        int          lat;
        logic [15:0] ta;
        logic [15:0] tb_;
        logic        tc;
        logic        ts;
        logic [17:0] exp;
        for (int i = 0; i < 3; i++) begin
            ta  = 16'($urandom);
            tb_ = 16'($urandom);
            tc  = 1'($urandom_range(0, 1));
            ts  = 1'(i == 1);
            exp = model(ta, tb_, tc, ts);
            run_op(k, ta, tb_, tc, ts, lat);
            n_cmp++;
            if (lat !== exp_lat || {ovf_w[k], car_w[k], sum_w[k]} !== exp) begin
                n_bad++;
                $display("FAIL config[%0d/%0d]: got lat=%0d ov/c/sum=%h want lat=%0d %h",
                         k, i, lat, {ovf_w[k], car_w[k], sum_w[k]}, exp_lat, exp);
            end
            release_op(k);
        end
    endtask

    // Random valid/ready stream; results must arrive in order and match the model.
    task automatic test_back_to_back(input int k, input int nops);
        logic [17:0] q[$];
        logic [17:0] exp;
        int          issued;
        int          done;
        int          cyc;
        issued = 0;
        done   = 0;
        cyc    = 0;
        while (done < nops && cyc < nops * 60) begin
            @(negedge clk);
            cyc++;
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            valid[k] = (issued < nops) && ($urandom_range(0, 3) != 0);
            ready[k] = ($urandom_range(0, 2) != 0);
            if (valid[k] && rdy_w[k]) begin
                q.push_back(model(a, b, cin, sub));
                issued++;
            end
            if (vld_w[k] && ready[k]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream[%0d]: got unexpected result %h want none",
                             k, {ovf_w[k], car_w[k], sum_w[k]});
                end else begin
                    exp = q.pop_front();
                    if ({ovf_w[k], car_w[k], sum_w[k]} !== exp) begin
                        n_bad++;
                        $display("FAIL stream[%0d] op %0d: got ov/c/sum=%h want %h",
                                 k, done, {ovf_w[k], car_w[k], sum_w[k]}, exp);
                    end
                end
                done++;
            end
        end
        n_cmp++;
        if (done !== nops) begin
            n_bad++;
            $display("FAIL stream_timeout[%0d]: got %0d results want %0d", k, done, nops);
        end
        @(negedge clk);
        valid[k] = 1'b0;
        ready[k] = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            ready[k] = 1'b0;
        end
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back(0, 1000);
        test_config(1, 16);
        test_config(2, 1);
        test_back_to_back(1, 150);
        test_back_to_back(2, 300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
